multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit.
//
// Sequences FETCH/DECODE/execute/writeback for data-processing, LDR/STR and
// branch instructions, decodes the ALU command, keeps the NZCV flags and
// evaluates the condition field.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   Instr       instruction bits [31:12] (cond, op, funct, Rn, Rd)
//   ALUFlags    {N,Z,C,V} from the ALU this cycle
//   mem_ready   memory access completes this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   datapath write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc    datapath mux selects
//   ImmSrc, RegSrc, ALUControl             extend / regfile / ALU controls
//   shift_flag  forward shifter output instead of ALU result (MOV)
//   state       current FSM state
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        shift_flag,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    state_e state_q, state_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign cmd   = funct[4:1];

    // Register fields are datapath-only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr[7:0];

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       cond_ex_q;

    // Condition evaluation against the committed flags {N,Z,C,V}.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // ALU command decode.
    logic [1:0] alu_dec;
    logic       cmd_writes;
    logic       cmd_is_cmp;
    logic       cmd_is_mov;

    always_comb begin
        alu_dec    = 2'b00;
        cmd_writes = 1'b0;
        cmd_is_cmp = 1'b0;
        cmd_is_mov = 1'b0;
        case (cmd)
            4'b0100: cmd_writes = 1'b1;
            4'b0010: begin alu_dec = 2'b01; cmd_writes = 1'b1; end
            4'b0000: begin alu_dec = 2'b10; cmd_writes = 1'b1; end
            4'b1100: begin alu_dec = 2'b11; cmd_writes = 1'b1; end
            4'b1010: begin alu_dec = 2'b01; cmd_is_cmp = 1'b1; end
            4'b1101: begin cmd_writes = 1'b1; cmd_is_mov = 1'b1; end
            default: ;
        endcase
    end

    logic in_exec;
    logic flags_upd;

    assign in_exec   = (state_q == StExecR) || (state_q == StExecI);
    assign flags_upd = in_exec && (funct[0] || cmd_is_cmp) && cond_ex_q;

    // cond_ex_q freezes the condition at DECODE so that a flag update made by
    // this instruction's execute edge cannot change its own writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                cond_ex_q <= cond_ex;
            end
            if (flags_upd) begin
                flags_q[3:2] <= ALUFlags[3:2];
                // Logical ops leave C and V untouched.
                if (!alu_dec[1]) begin
                    flags_q[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExecR,
            StExecI:  state_d = StAluWb;
            StAluWb,
            StMemWb,
            StBranch: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    logic pc_we, ir_we, reg_we, mem_we;

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        shift_flag = 1'b0;
        ImmSrc     = op;
        RegSrc     = {op == 2'b01, op == 2'b10};
        case (state_q)
            StFetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_we     = mem_ready;
                ir_we     = mem_ready;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc = 1'b1;
            StMemWr: begin
                AdrSrc = 1'b1;
                mem_we = cond_ex_q;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_we    = cond_ex_q;
            end
            StExecR,
            StExecI: begin
                ALUSrcB    = (state_q == StExecI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                shift_flag = cmd_is_mov;
            end
            StAluWb:  reg_we = cond_ex_q && cmd_writes;
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = cond_ex_q;
            end
            default: ;
        endcase
    end

    // Enables are forced low asynchronously while reset is held.
    assign PCWrite  = pc_we  & reset;
    assign IRWrite  = ir_we  & reset;
    assign RegWrite = reg_we & reset;
    assign MemWrite = mem_we & reset;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
    localparam int ER = 6, EI = 7, AW = 8, BR = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, shift_flag;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  state;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .shift_flag (shift_flag),
        .state      (state)
    );

    always #5 clk = ~clk;

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,
    //  ImmSrc,RegSrc,ALUControl,shift_flag,state}
    logic [20:0] act;
    assign act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  ImmSrc, RegSrc, ALUControl, shift_flag, state};

    int tests_run = 0;
    int tests_failed = 0;
    logic [20:0] exp_q[$];
    logic [3:0]  m_flags = 4'b0000;

    task automatic check(input string name, input logic [20:0] a, input logic [20:0] e);
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)",
                     name, $time, a, a[3:0], e, e[3:0]);
        end
    endtask

    // Monitor: one expected output record per cycle, sampled mid-cycle.
    logic [20:0] mon_e;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", act, mon_e);
        end
    end

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic bit cmd_writes(input logic [3:0] cmd);
        return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101};
    endfunction

    function automatic logic [20:0] expect_out(input int st, input bit mr, input bit pass,
                                               input logic [19:0] ins);
        logic [1:0] op, asb, rs, alu;
        logic [3:0] cmd;
        logic pcw, irw, rw, mw, adr, asa, sh;
        op = ins[15:14]; cmd = ins[12:9];
        pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; asa = 0; sh = 0;
        asb = 2'b00; rs = 2'b00; alu = 2'b00;
        case (st)
            F:   begin asa = 1; asb = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
            D:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
            MA:  asb = 2'b01;
            MR:  adr = 1;
            MW:  begin adr = 1; mw = pass; end
            MWB: begin rs = 2'b01; rw = pass; end
            ER, EI: begin
                asb = (st == EI) ? 2'b01 : 2'b00;
                alu = alu_of(cmd);
                sh  = (cmd == 4'b1101);
            end
            AW:  rw = pass && cmd_writes(cmd);
            BR:  begin asb = 2'b01; rs = 2'b10; pcw = pass; end
            default: ;
        endcase
        return {pcw, irw, rw, mw, adr, asa, asb, rs, op, op == 2'b01, op == 2'b10, alu, sh,
                st[3:0]};
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] fn);
        logic [7:0] regs;
        regs = 8'($urandom);
        return {c, op, fn, regs};
    endfunction

    // Drives one instruction through its whole state walk. stalls < 0 gives
    // random mem_ready; otherwise that many wait cycles in MEMRD/MEMWR.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] fl, input int stalls,
                             input bit abort);
        int phases[$];
        bit pass, mr, funct0;
        logic [3:0] cmd;
        logic [1:0] op, ac;
        int n;
        op = ins[15:14]; cmd = ins[12:9]; funct0 = ins[8];
        phases = {F, D};
        case (op)
            2'b01: begin
                phases.push_back(MA);
                if (funct0) begin phases.push_back(MR); phases.push_back(MWB); end
                else phases.push_back(MW);
            end
            2'b00: begin phases.push_back(ins[13] ? EI : ER); phases.push_back(AW); end
            2'b10: phases.push_back(BR);
            default: ;
        endcase
        pass  = cond_pass(ins[19:16], m_flags);
        Instr = ins;
        foreach (phases[i]) begin
            n = 0;
            forever begin
                if (phases[i] == F || phases[i] == MR || phases[i] == MW) begin
                    if (stalls < 0) mr = ($urandom_range(0, 3) != 0);
                    else mr = (phases[i] == F) ? 1'b1 : (n >= stalls);
                end else begin
                    mr = 1'($urandom_range(0, 1));
                end
                mem_ready = mr;
                ALUFlags  = (phases[i] == ER || phases[i] == EI) ? fl : 4'($urandom);
                exp_q.push_back(expect_out(phases[i], mr, pass, ins));
                if (abort && phases[i] == MW) begin
                    @(negedge clk);
                    mem_ready = 1'b1;
                    #2 reset = 1'b0;
                    #1 check("reset_abort", act, expect_out(F, 1'b0, pass, ins));
                    m_flags = 4'b0000;
                    @(posedge clk);
                    #1 reset = 1'b1;
                    return;
                end
                @(posedge clk);
                #1;
                n++;
                if ((phases[i] == ER || phases[i] == EI) && pass &&
                    (funct0 || cmd == 4'b1010)) begin
                    ac = alu_of(cmd);
                    m_flags[3:2] = fl[3:2];
                    if (!ac[1]) m_flags[1:0] = fl[1:0];
                end
                if (!((phases[i] == F || phases[i] == MR || phases[i] == MW) && !mr)) break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset holds FETCH with enables low even with mem_ready high.
        reset = 1'b0;
        mem_ready = 1'b1;
        Instr = '0;
        #1 check("reset_state", act, expect_out(F, 1'b0, 1'b0, Instr));
        repeat (2) @(posedge clk);
        #1 check("reset_hold", act, expect_out(F, 1'b0, 1'b0, Instr));
        reset = 1'b1;

        // ADD R1,R2,R3
        run_instr(mk(4'hE, 2'b00, 6'b001000), 4'($urandom), 0, 1'b0);
        // SUBS Z=1 then BEQ taken; SUBS Z=0 then BEQ not taken
        run_instr(mk(4'hE, 2'b00, 6'b000101), 4'b0100, 0, 1'b0);
        run_instr(mk(4'h0, 2'b10, 6'($urandom)), 4'h0, 0, 1'b0);
        run_instr(mk(4'hE, 2'b00, 6'b000101), 4'b0000, 0, 1'b0);
        run_instr(mk(4'h0, 2'b10, 6'($urandom)), 4'h0, 0, 1'b0);
        // LDR with three MEMRD stall cycles
        run_instr(mk(4'hE, 2'b01, 6'b011001), 4'h0, 3, 1'b0);
        // MOVNE with Z=1: suppressed write
        run_instr(mk(4'hE, 2'b00, 6'b000101), 4'b0100, 0, 1'b0);
        run_instr(mk(4'h1, 2'b00, 6'b011010), 4'h0, 0, 1'b0);
        // CMP (S=0) still writes flags: N=1, then BMI taken
        run_instr(mk(4'hE, 2'b00, 6'b010100), 4'b1010, 0, 1'b0);
        run_instr(mk(4'h4, 2'b10, 6'($urandom)), 4'h0, 0, 1'b0);
        // ANDS keeps C,V: set all, then ANDS with 0000, then BCS taken
        run_instr(mk(4'hE, 2'b00, 6'b001001), 4'b1111, 0, 1'b0);
        run_instr(mk(4'hE, 2'b00, 6'b000001), 4'b0000, 0, 1'b0);
        run_instr(mk(4'h2, 2'b10, 6'($urandom)), 4'h0, 0, 1'b0);
        // Undefined op=11 goes straight back to FETCH
        run_instr(mk(4'hE, 2'b11, 6'($urandom)), 4'h0, 0, 1'b0);
        // Set all flags, then STR aborted by reset mid-stall
        run_instr(mk(4'hE, 2'b00, 6'b001001), 4'b1111, 0, 1'b0);
        run_instr(mk(4'hE, 2'b01, 6'b011000), 4'h0, 4, 1'b1);
        // Flags cleared by reset: EQ/CS/MI/VS not taken, NE taken
        run_instr(mk(4'h0, 2'b10, 6'h00), 4'h0, 0, 1'b0);
        run_instr(mk(4'h2, 2'b10, 6'h00), 4'h0, 0, 1'b0);
        run_instr(mk(4'h4, 2'b10, 6'h00), 4'h0, 0, 1'b0);
        run_instr(mk(4'h6, 2'b10, 6'h00), 4'h0, 0, 1'b0);
        run_instr(mk(4'h1, 2'b10, 6'h00), 4'h0, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            run_instr(mk(4'($urandom), 2'($urandom), 6'($urandom)), 4'($urandom), -1, 1'b0);
        end

        repeat (3) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
